calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
Sequencer between the UART command parser and the calculator ALU/UART transmitter.
- On each parsed command, checks the operands, starts the multi-cycle ALU and waits for completion.
- Streams the result back as uppercase ASCII hex followed by CR LF, using a valid/ready handshake into the TX path.
- Emits "ERR\r\n" for illegal commands or ALU timeout.

Parameters:
RES_W, 32, ALU result width in bits (multiple of 4).
N_DIGITS, 8, hex digits in the result (RES_W/4).
ALU_TIMEOUT, 64, max cycles from alu_start to alu_done before error.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
parser_done  input  1  one-cycle pulse; command operands valid this cycle.
operator  input  5  1:+ 2:- 3:* 4:/, other codes illegal.
src1  input  16  first operand.
src2  input  16  second operand.
alu_start  output  1  one-cycle start pulse to ALU.
alu_op  output  5  latched operator to ALU.
alu_a  output  16  latched src1.
alu_b  output  16  latched src2.
alu_done  input  1  one-cycle pulse; alu_result valid.
alu_result  input  RES_W  ALU result.
tx_data  output  8  ASCII byte to UART TX.
tx_valid  output  1  tx_data valid.
tx_ready  input  1  TX accepts byte when tx_valid&&tx_ready.
busy  output  1  high in every state except IDLE.
err  output  1  one-cycle pulse when an error sequence starts.

Behaviour:
Reset values:
- All outputs 0; state IDLE; internal registers cleared.
- rst aborts any operation the next edge, including mid-byte: tx_valid is 0 the cycle after rst.

States and transitions:
- IDLE: on parser_done, latch operator/src1/src2 into alu_op/alu_a/alu_b -> CHECK. parser_done is ignored in all other states; it is not queued.
- CHECK (1 cycle):
  - If operator not in 1..4, or operator==4 with src2==0 -> ERR.
  - Otherwise -> RUN, with alu_start=1 for exactly the first RUN cycle.
- RUN:
  - Timeout counter clears on entry and increments each cycle.
  - alu_done is honoured from the cycle after alu_start onward; on alu_done, latch alu_result into the shift register -> SKIP.
  - If the counter reaches ALU_TIMEOUT without alu_done -> ERR.
  - alu_done outside RUN is ignored.
- SKIP: while the top nibble ==0 and digits remaining >1, shift left 4 and decrement the remaining count, one nibble per cycle. Then -> SEND.
  - Leading zeros are suppressed; at least one digit is always sent. Result 0 sends "0".
- SEND: tx_data = ASCII of the top nibble (0-9 -> 0x30-0x39, A-F -> 0x41-0x46). On handshake, shift left 4 and decrement; after the last digit -> CR.
- CR: send 0x0D -> LF.
- LF: send 0x0A -> IDLE.
- ERR: err=1 on the entry cycle only. Send 0x45, 0x52, 0x52 ("ERR"), then -> CR.

Handshake rules:
- tx_valid is registered. Once asserted, tx_valid and tx_data hold stable until tx_ready is sampled high.
- Next byte presented no earlier than the cycle after acceptance; no combinational path tx_ready -> tx_valid.
- Back-to-back bytes at one per 2 cycles max is acceptable.

Result width: only RES_W bits of alu_result are used; subtraction results are sent as the raw two's-complement hex (e.g. 1-2 -> "FFFFFFFF").

busy asserts the cycle after parser_done is accepted and deasserts in the cycle IDLE is re-entered.

Test Plan:
- operator=1, src1=0x0001, src2=0x0002, ALU returns 0x3 after 4 cycles -> one alu_start pulse, alu_a=1, alu_b=2; TX bytes 0x33,0x0D,0x0A; busy low after LF accepted.
- operator=3, src1=0x1234, src2=0x0010, result 0x00012340, tx_ready toggling 1/0 -> bytes "12340\r\n" in order; tx_data stable whenever tx_valid&&!tx_ready.
- Result 0x00000000 -> exactly "0\r\n"; result 0xFFFFFFFF -> "FFFFFFFF\r\n".
- operator=4, src2=0 -> err pulse once, alu_start never asserted, bytes 0x45,0x52,0x52,0x0D,0x0A. operator=7 -> same.
- ALU never returns alu_done -> err at cycle ALU_TIMEOUT after alu_start, "ERR\r\n". A late alu_done afterwards is ignored.
- parser_done pulsed during SEND -> ignored (no new alu_start). rst asserted mid-digit -> tx_valid=0, busy=0 next cycle; the next command then runs normally.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: checks a parsed command, runs the ALU, then streams the
// result to the UART TX as uppercase hex + CR LF, or "ERR\r\n" on failure.
module calc_seq_ctrl #(
  parameter int RES_W       = 32,
  parameter int N_DIGITS    = 8,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parser_done,
  input  logic [4:0]       operator,
  input  logic [15:0]      src1,
  input  logic [15:0]      src2,
  output logic             alu_start,
  output logic [4:0]       alu_op,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  input  logic             alu_done,
  input  logic [RES_W-1:0] alu_result,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             err
);

  localparam int DIG_W = $clog2(N_DIGITS + 1);
  localparam int TMO_W = $clog2(ALU_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_RUN, S_SKIP, S_SEND, S_CR, S_LF, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [15:0]      a_q, a_d, b_q, b_d;
  logic             start_q, start_d;
  logic [RES_W-1:0] shift_q, shift_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             txv_q, txv_d;
  logic [7:0]       txd_q, txd_d;
  logic             err_q, err_d;
  logic [1:0]       eidx_q, eidx_d;

  logic             sending;
  logic [7:0]       send_byte;
  logic             accepted;
  logic             illegal;
  logic [3:0]       top_nib;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign accepted = txv_q && tx_ready;
  assign top_nib  = shift_q[RES_W-1 -: 4];
  assign illegal  = (op_q == 5'd0) || (op_q > 5'd4) || ((op_q == 5'd4) && (b_q == 16'd0));

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    start_d   = 1'b0;
    shift_d   = shift_q;
    dig_d     = dig_q;
    tmo_d     = tmo_q;
    txv_d     = txv_q;
    txd_d     = txd_q;
    err_d     = 1'b0;
    eidx_d    = eidx_q;
    sending   = 1'b0;
    send_byte = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (parser_done) begin
          op_d    = operator;
          a_d     = src1;
          b_d     = src2;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (illegal) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          eidx_d  = 2'd0;
        end else begin
          state_d = S_RUN;
          start_d = 1'b1;
          tmo_d   = '0;
        end
      end
      S_RUN: begin
        tmo_d = tmo_q + 1'b1;
        // alu_done during the alu_start cycle itself cannot belong to this command
        if (alu_done && !start_q) begin
          shift_d = alu_result;
          dig_d   = DIG_W'(N_DIGITS);
          state_d = S_SKIP;
        end else if (tmo_q == TMO_W'(ALU_TIMEOUT - 1)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          eidx_d  = 2'd0;
        end
      end
      S_SKIP: begin
        if ((top_nib == 4'd0) && (dig_q > DIG_W'(1))) begin
          shift_d = {shift_q[RES_W-5:0], 4'h0};
          dig_d   = dig_q - 1'b1;
        end else begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        sending   = 1'b1;
        send_byte = hex_ascii(top_nib);
        if (accepted) begin
          shift_d = {shift_q[RES_W-5:0], 4'h0};
          dig_d   = dig_q - 1'b1;
          if (dig_q == DIG_W'(1)) state_d = S_CR;
        end
      end
      S_CR: begin
        sending   = 1'b1;
        send_byte = 8'h0D;
        if (accepted) state_d = S_LF;
      end
      S_LF: begin
        sending   = 1'b1;
        send_byte = 8'h0A;
        if (accepted) state_d = S_IDLE;
      end
      S_ERR: begin
        sending   = 1'b1;
        send_byte = (eidx_q == 2'd0) ? 8'h45 : 8'h52;
        if (accepted) begin
          eidx_d = eidx_q + 1'b1;
          if (eidx_q == 2'd2) state_d = S_CR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered valid: present a byte, hold it until taken, then leave one idle cycle.
    if (sending) begin
      if (!txv_q) begin
        txv_d = 1'b1;
        txd_d = send_byte;
      end else if (tx_ready) begin
        txv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      start_q <= 1'b0;
      shift_q <= '0;
      dig_q   <= '0;
      tmo_q   <= '0;
      txv_q   <= 1'b0;
      txd_q   <= '0;
      err_q   <= 1'b0;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      start_q <= start_d;
      shift_q <= shift_d;
      dig_q   <= dig_d;
      tmo_q   <= tmo_d;
      txv_q   <= txv_d;
      txd_q   <= txd_d;
      err_q   <= err_d;
      eidx_q  <= eidx_d;
    end
  end

  assign alu_start = start_q;
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign tx_data   = txd_q;
  assign tx_valid  = txv_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Randomized scoreboard bench for calc_seq_ctrl: expected TX bytes and ALU
// requests are queued at issue time and popped by an independent monitor.
module tb_calc_seq_ctrl;
  localparam int RES_W = 32, N_DIGITS = 8, ALU_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst, parser_done, alu_done, tx_ready;
  logic [4:0]  operator;
  logic [15:0] src1, src2;
  logic [31:0] alu_result;
  logic        alu_start, tx_valid, busy, err;
  logic [4:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic [7:0]  tx_data;

  calc_seq_ctrl #(.RES_W(RES_W), .N_DIGITS(N_DIGITS), .ALU_TIMEOUT(ALU_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .parser_done(parser_done), .operator(operator),
    .src1(src1), .src2(src2), .alu_start(alu_start), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done), .alu_result(alu_result),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
  } alu_t;

  int          total = 0, bad = 0;
  byte unsigned exp_q[$];
  alu_t        alu_q[$];
  int          ready_mode = 0, alu_delay = 4;
  bit          alu_nodone = 0;
  int          done_cnt = 0, late_cnt = 0;
  logic [31:0] pend_res;
  int          cyc = 0, start_cyc = 0, err_cyc = 0, err_seen = 0, err_exp = 0;
  bit          prev_stall = 0, idle_chk = 0;
  logic [7:0]  prev_data;
  byte unsigned mon_b;
  alu_t        mon_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Input driver: TX back-pressure and the ALU's delayed completion pulse.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    alu_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin alu_done = 1'b1; alu_result = pend_res; end
    end
    if (late_cnt > 0) begin
      late_cnt--;
      if (late_cnt == 0) begin alu_done = 1'b1; alu_result = 32'h0000_1234; end
    end
  end

  // Monitor: pops the scoreboard on every handshake and ALU start.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 0;
      idle_chk   = 0;
    end else begin
      if (idle_chk) begin check("busy_after_lf", busy, 0); idle_chk = 0; end
      if (prev_stall) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_byte: got %02h want none", tx_data);
        end else begin
          mon_b = exp_q.pop_front();
          check("tx_byte", tx_data, mon_b);
          if (exp_q.size() == 0) idle_chk = 1;
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (alu_start) begin
        start_cyc = cyc;
        if (alu_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_alu_start: got op=%0d want none", alu_op);
        end else begin
          mon_a = alu_q.pop_front();
          check("alu_op", alu_op, mon_a.op);
          check("alu_a", alu_a, mon_a.a);
          check("alu_b", alu_b, mon_a.b);
          if (alu_nodone) late_cnt = ALU_TIMEOUT + 3;
          else begin done_cnt = alu_delay; pend_res = mon_a.res; end
        end
      end
      if (err) begin err_seen++; err_cyc = cyc; end
    end
  end

  task automatic push_err();
    exp_q.push_back(8'h45); exp_q.push_back(8'h52); exp_q.push_back(8'h52);
    err_exp++;
  endtask

  task automatic push_hex(input logic [31:0] value);
    byte unsigned digits[$];
    logic [31:0] v = value;
    int n;
    do begin
      n = int'(v % 16);
      digits.push_front(n < 10 ? byte'(48 + n) : byte'(55 + n));
      v = v / 16;
    end while (v != 0);
    foreach (digits[i]) exp_q.push_back(digits[i]);
  endtask

  task automatic pulse_cmd(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #2;
    parser_done = 1'b1; operator = op; src1 = a; src2 = b;
    @(posedge clk); #2;
    parser_done = 1'b0; operator = 5'($urandom); src1 = 16'($urandom); src2 = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0 || late_cnt != 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy=%0b left=%0d want idle", busy, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    check("alu_starts_left", alu_q.size(), 0);
    check("err_count", err_seen, err_exp);
  endtask

  task automatic wait_left(input int left);
    int n = 0;
    while (exp_q.size() > left && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL byte_wait: got left=%0d want <=%0d", exp_q.size(), left);
    end
  endtask

  task automatic send_cmd(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input bit do_wait);
    logic [31:0] res;
    if (op < 1 || op > 4 || (op == 4 && b == 0)) begin
      push_err();
    end else begin
      case (op)
        5'd1:    res = 32'(a) + 32'(b);
        5'd2:    res = 32'(a) - 32'(b);
        5'd3:    res = 32'(a) * 32'(b);
        default: res = 32'(a) / 32'(b);
      endcase
      if (alu_nodone) push_err(); else push_hex(res);
      alu_q.push_back('{op, a, b, res});
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    pulse_cmd(op, a, b);
    if (do_wait) wait_idle();
  endtask

  task automatic do_reset_mid();
    @(posedge clk); #2;
    rst = 1'b1; done_cnt = 0; late_cnt = 0;
    @(posedge clk); #2;
    rst = 1'b0; exp_q.delete(); alu_q.delete();
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
  endtask

  initial begin
    logic [4:0]  op;
    logic [15:0] a, b;
    rst = 1'b1; parser_done = 1'b0; operator = '0; src1 = '0; src2 = '0;
    alu_done = 1'b0; alu_result = '0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_tx_valid", tx_valid, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_alu_start", alu_start, 0);
    check("reset_alu_op", alu_op, 0);
    check("reset_alu_a", alu_a, 0);
    check("reset_alu_b", alu_b, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);

    ready_mode = 0; alu_delay = 4;  send_cmd(5'd1, 16'h0001, 16'h0002, 1);
    ready_mode = 1; alu_delay = 7;  send_cmd(5'd3, 16'h1234, 16'h0010, 1);
    ready_mode = 0; alu_delay = 1;  send_cmd(5'd1, 16'h0000, 16'h0000, 1);
    ready_mode = 2; alu_delay = ALU_TIMEOUT - 1; send_cmd(5'd2, 16'h0000, 16'h0001, 1);
    ready_mode = 0; send_cmd(5'd4, 16'h0005, 16'h0000, 1);
    send_cmd(5'd7, 16'h0001, 16'h0001, 1);
    send_cmd(5'd0, 16'h0003, 16'h0003, 1);

    alu_nodone = 1;
    send_cmd(5'd1, 16'h0003, 16'h0004, 1);
    check("timeout_latency", err_cyc - start_cyc, ALU_TIMEOUT);
    alu_nodone = 0;

    // A second command while the result is streaming must be dropped.
    alu_delay = 5;
    send_cmd(5'd3, 16'h1234, 16'h0010, 0);
    wait_left(5);
    pulse_cmd(5'd1, 16'h0009, 16'h0009);
    wait_idle();

    send_cmd(5'd3, 16'h1234, 16'h0010, 0);
    wait_left(5);
    do_reset_mid();
    send_cmd(5'd1, 16'h0001, 16'h0002, 1);

    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 7));
      if ($urandom % 4 != 0) op = 5'($urandom_range(1, 4));
      a = 16'($urandom);
      b = ($urandom % 5 == 0) ? 16'h0000 : 16'($urandom);
      ready_mode = int'($urandom % 3);
      alu_delay = int'($urandom_range(1, ALU_TIMEOUT - 1));
      send_cmd(op, a, b, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "simulation time limit");
  end
endmodule
